// File: rtl/bus_arbiter_4_way_16_if.sv
// Handshake/bus bundle between four requesters, the arbiter and its downstream consumer.
interface bus_arbiter_4_way_16_if;
  logic [3:0]  req;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] d;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out;
  logic [1:0]  select;
  logic [3:0]  grant;
  logic [3:0]  done;

  modport slave (
    input  req, a, b, c, d, out_ready,
    output out_valid, out, select, grant, done
  );

  modport master (
    output req, a, b, c, d, out_ready,
    input  out_valid, out, select, grant, done
  );
endinterface

// File: rtl/bus_arbiter_4_way_16.sv
// Four-way round-robin arbiter: captures the winner's 16-bit word and holds it until downstream accepts.
module bus_arbiter_4_way_16 (
  input logic                    clock,
  input logic                    reset,
  bus_arbiter_4_way_16_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [1:0]  last_q;
  logic [1:0]  select_q;
  logic [3:0]  grant_q;
  logic [15:0] out_q;
  logic        out_valid_q;

  logic [1:0]  idx [4];
  logic [1:0]  winner_d;
  logic [15:0] word_d;

  // idx[0] is the highest-priority candidate (last+1), idx[3] is last itself.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign idx[gi] = last_q + 2'(gi + 1);
    end
  endgenerate

  always_comb begin
    winner_d = idx[0];
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[idx[k]]) winner_d = idx[k];
    end
  end

  always_comb begin
    word_d = bus.a;
    case (winner_d)
      2'd0:    word_d = bus.a;
      2'd1:    word_d = bus.b;
      2'd2:    word_d = bus.c;
      default: word_d = bus.d;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      select_q    <= 2'd0;
      grant_q     <= 4'b0000;
      out_q       <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 4'b0000) begin
            state_q     <= BUSY;
            select_q    <= winner_d;
            grant_q     <= 4'b0001 << winner_d;
            out_q       <= word_d;
            out_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          // Captured word and grant are frozen until downstream accepts; req is not looked at.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            last_q      <= select_q;
            grant_q     <= 4'b0000;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.select    = select_q;
  assign bus.grant     = grant_q;
  assign bus.done      = (out_valid_q && bus.out_ready) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_bus_arbiter_4_way_16.sv
// Directed bench for bus_arbiter_4_way_16: vector table plus hand-written backpressure and reset sequences.
module tb_bus_arbiter_4_way_16;

  logic clock;
  logic reset;

  bus_arbiter_4_way_16_if bus ();

  bus_arbiter_4_way_16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] b_word;
    logic        rdy;
    logic        ev;
    logic [15:0] eo;
    logic [1:0]  es;
    logic [3:0]  eg;
    logic [3:0]  ed;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [15:0] eo,
                         input logic [1:0] es, input logic [3:0] eg, input logic [3:0] ed);
    chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'(ev));
    chk({tag, ".out"},       bus.out,            eo);
    chk({tag, ".select"},    16'(bus.select),    16'(es));
    chk({tag, ".grant"},     16'(bus.grant),     16'(eg));
    chk({tag, ".done"},      16'(bus.done),      16'(ed));
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [15:0] bw, input logic rdy,
                              input logic ev, input logic [15:0] eo, input logic [1:0] es,
                              input logic [3:0] eg, input logic [3:0] ed);
    vec_t v;
    v.req = req; v.b_word = bw; v.rdy = rdy;
    v.ev = ev; v.eo = eo; v.es = es; v.eg = eg; v.ed = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Fairness from reset (last=3), single request, idle hold, wrap 2->3->0.
    vecs[0]  = mk(4'b1111, 16'hB001, 1'b1, 1'b1, 16'hA000, 2'd0, 4'b0001, 4'b0001);
    vecs[1]  = mk(4'b1111, 16'hB001, 1'b1, 1'b0, 16'hA000, 2'd0, 4'b0000, 4'b0000);
    vecs[2]  = mk(4'b1111, 16'hB001, 1'b1, 1'b1, 16'hB001, 2'd1, 4'b0010, 4'b0010);
    vecs[3]  = mk(4'b1111, 16'hB001, 1'b1, 1'b0, 16'hB001, 2'd1, 4'b0000, 4'b0000);
    vecs[4]  = mk(4'b1111, 16'hB001, 1'b1, 1'b1, 16'hC002, 2'd2, 4'b0100, 4'b0100);
    vecs[5]  = mk(4'b1111, 16'hB001, 1'b1, 1'b0, 16'hC002, 2'd2, 4'b0000, 4'b0000);
    vecs[6]  = mk(4'b1111, 16'hB001, 1'b1, 1'b1, 16'hD003, 2'd3, 4'b1000, 4'b1000);
    vecs[7]  = mk(4'b1111, 16'hB001, 1'b1, 1'b0, 16'hD003, 2'd3, 4'b0000, 4'b0000);
    vecs[8]  = mk(4'b1111, 16'hB001, 1'b1, 1'b1, 16'hA000, 2'd0, 4'b0001, 4'b0001);
    vecs[9]  = mk(4'b0000, 16'hB001, 1'b1, 1'b0, 16'hA000, 2'd0, 4'b0000, 4'b0000);
    vecs[10] = mk(4'b0010, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 2'd1, 4'b0010, 4'b0010);
    vecs[11] = mk(4'b0000, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 2'd1, 4'b0000, 4'b0000);
    vecs[12] = mk(4'b0000, 16'hB001, 1'b1, 1'b0, 16'hBEEF, 2'd1, 4'b0000, 4'b0000);
    vecs[13] = mk(4'b0100, 16'hB001, 1'b1, 1'b1, 16'hC002, 2'd2, 4'b0100, 4'b0100);
    vecs[14] = mk(4'b0000, 16'hB001, 1'b1, 1'b0, 16'hC002, 2'd2, 4'b0000, 4'b0000);
    vecs[15] = mk(4'b1001, 16'hB001, 1'b1, 1'b1, 16'hD003, 2'd3, 4'b1000, 4'b1000);
    vecs[16] = mk(4'b0000, 16'hB001, 1'b1, 1'b0, 16'hD003, 2'd3, 4'b0000, 4'b0000);
    vecs[17] = mk(4'b1001, 16'hB001, 1'b1, 1'b1, 16'hA000, 2'd0, 4'b0001, 4'b0001);
    vecs[18] = mk(4'b0000, 16'hB001, 1'b1, 1'b0, 16'hA000, 2'd0, 4'b0000, 4'b0000);

    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.a         = 16'hA000;
    bus.b         = 16'hB001;
    bus.c         = 16'hC002;
    bus.d         = 16'hD003;
    bus.out_ready = 1'b1;
    #2;
    chk_all("reset_init", 1'b0, 16'h0000, 2'd0, 4'b0000, 4'b0000);

    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.req       = vecs[i].req;
      bus.b         = vecs[i].b_word;
      bus.out_ready = vecs[i].rdy;
      tick();
      $display("vec %0d: req=%b rdy=%b -> valid=%b out=%h sel=%0d grant=%b done=%b",
               i, vecs[i].req, vecs[i].rdy, bus.out_valid, bus.out, bus.select, bus.grant, bus.done);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].es, vecs[i].eg, vecs[i].ed);
    end

    // Backpressure: last=0 here, requester 2 wins, then stalls while inputs churn.
    bus.b         = 16'hB001;
    bus.req       = 4'b0100;
    bus.c         = 16'h1234;
    bus.out_ready = 1'b0;
    tick();
    $display("bp grant: valid=%b out=%h grant=%b", bus.out_valid, bus.out, bus.grant);
    chk_all("bp_grant", 1'b1, 16'h1234, 2'd2, 4'b0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      bus.c   = 16'hFFFF;
      bus.req = 4'b0101;
      tick();
      $display("bp stall %0d: valid=%b out=%h grant=%b done=%b", i, bus.out_valid, bus.out, bus.grant, bus.done);
      chk_all($sformatf("bp_stall%0d", i), 1'b1, 16'h1234, 2'd2, 4'b0100, 4'b0000);
    end
    bus.out_ready = 1'b1;
    #1;
    $display("bp accept: done=%b", bus.done);
    chk("bp_done", 16'(bus.done), 16'h0004);
    tick();
    bus.req = 4'b0001;
    $display("bp idle: valid=%b grant=%b", bus.out_valid, bus.grant);
    chk_all("bp_idle", 1'b0, 16'h1234, 2'd2, 4'b0000, 4'b0000);
    tick();
    $display("bp next: valid=%b sel=%0d grant=%b", bus.out_valid, bus.select, bus.grant);
    chk_all("bp_next", 1'b1, 16'hA000, 2'd0, 4'b0001, 4'b0001);

    // Asynchronous reset mid-BUSY with a stalled consumer.
    bus.out_ready = 1'b0;
    bus.req       = 4'b0000;
    #3;
    reset = 1'b1;
    #1;
    $display("mid reset: valid=%b out=%h grant=%b done=%b", bus.out_valid, bus.out, bus.grant, bus.done);
    chk_all("rst_async", 1'b0, 16'h0000, 2'd0, 4'b0000, 4'b0000);
    bus.out_ready = 1'b1;
    #1;
    chk("rst_no_done", 16'(bus.done), 16'h0000);
    bus.req = 4'b0001;
    tick();
    chk("rst_held_valid", 16'(bus.out_valid), 16'h0000);
    #2;
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    $display("post reset: valid=%b sel=%0d grant=%b", bus.out_valid, bus.select, bus.grant);
    chk_all("rst_resume", 1'b1, 16'hA000, 2'd0, 4'b0001, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4_way_16.md
BUS_ARBITER_4_WAY_16 -- requirements
Module: bus_arbiter_4_way_16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 req  input  4  per-requester transfer request, level, bit i = requester i.
REQ-005 a, b, c, d  input  16 each  requester 0..3 data words.
REQ-006 out_ready  input  1  downstream accepts out this cycle.
REQ-007 out_valid  output  1  out holds a granted word.
REQ-008 out  output  16  captured data word of the granted requester.
REQ-009 select  output  2  index of the granted requester (0=a, 1=b, 2=c, 3=d).
REQ-010 grant  output  4  one-hot copy of select, qualified by out_valid; all zeros when out_valid=0.
REQ-011 done  output  4  one-hot transfer-complete pulse to the granted requester.

Function
REQ-012 The block SHALL implement two states: IDLE and BUSY.
REQ-013 In IDLE with req=0, the block SHALL stay in IDLE and out_valid SHALL remain 0.
REQ-014 In IDLE with req!=0, the block SHALL pick the winner round-robin, searching indices last+1, last+2, last+3, last (mod 4), where last is the most recently completed winner.
REQ-015 On the IDLE->BUSY edge, the block SHALL register select=winner, grant=one-hot(winner), out=the winner's input word and out_valid=1.
REQ-016 Latency SHALL be one cycle: req sampled high at edge N -> out_valid=1 after edge N.
REQ-017 While in BUSY, out, select and grant SHALL stay stable regardless of changes on a..d or req.
REQ-018 A new request SHALL NOT preempt the current grant.
REQ-019 done SHALL be combinational: done = grant when out_valid && out_ready, else 0.
REQ-020 On an edge where out_valid && out_ready, the block SHALL:
- update last to select;
- clear out_valid and grant;
- return to IDLE.
REQ-021 Throughput SHALL be at most one transfer per two cycles (one mandatory IDLE cycle between grants).
REQ-022 A requester SHALL deassert req at the edge where its done is high, and the block SHALL rely on this.
- If req is still high in the following IDLE cycle, that requester SHALL be re-arbitrated with the lowest priority.
REQ-023 out_ready SHALL be ignored in IDLE.
REQ-024 out SHALL hold its last value after a transfer; only out_valid qualifies it.
REQ-025 last SHALL wrap from 3 to 0 modulo 4.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for a clock edge, force:
- state=IDLE;
- out_valid=0, grant=0, done=0;
- out=16'h0000, select=2'b00;
- last=3, so requester 0 has first priority.
REQ-027 A reset asserted during BUSY SHALL abort the transfer with no done pulse; arbitration SHALL resume at the first clock edge after reset deasserts.

Verification
REQ-028 Reset: assert reset asynchronously mid-cycle -> out_valid=0, grant=0000, done=0000, out=0000 before the next edge.
REQ-029 Single request: req=0010, b=16'hBEEF, out_ready=1.
- Next cycle: out_valid=1, out=BEEF, select=01, grant=0010, done=0010.
- Following cycle: out_valid=0.
REQ-030 Fairness: req=1111 held with each requester re-asserting after its done, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with an idle cycle between each.
REQ-031 Backpressure: grant to requester 2 with c=16'h1234, then out_ready=0 for 5 cycles while c changes to 16'hFFFF and req[0] rises.
- out SHALL stay 1234 and grant SHALL stay 0100.
- On out_ready=1: done=0100, and requester 0 is granted next.
REQ-032 Wrap: last=2, req=1001 -> requester 3 granted (select=11); after done, req=1001 again -> requester 0 granted.
REQ-033 Reset mid-BUSY: reset during a grant with out_ready=0 -> no done pulse, out_valid=0; after release with req=0001, requester 0 is granted one cycle later.
